// File: rtl/lut_prog.sv
// Field-programmable N-input lookup table with serial MSB-first reconfiguration.
// A shadow table is loaded bit by bit and swapped into the active table in one cycle.
module lut_prog #(
  parameter int                N           = 4,
  parameter logic [2**N-1:0]   RESET_TABLE = '0,
  parameter int                COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       x,
  input  logic               x_valid,
  input  logic               cfg_en,
  input  logic               cfg_bit,
  input  logic               cnt_clr,
  output logic               y,
  output logic               y_valid,
  output logic               busy,
  output logic               cfg_done,
  output logic [COUNT_W-1:0] hit_cnt
);

  localparam int DEPTH = 2**N;

  typedef logic [N:0]         bcnt_t;
  typedef logic [DEPTH-1:0]   table_t;
  typedef logic [COUNT_W-1:0] cnt_t;

  localparam bcnt_t LAST_BIT = bcnt_t'(DEPTH - 1);
  localparam cnt_t  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e state_q, state_d;
  table_t act_q,   act_d;
  table_t shd_q,   shd_d;
  bcnt_t  bcnt_q,  bcnt_d;
  logic   y_q,     y_d;
  logic   yv_q,    yv_d;
  logic   done_q,  done_d;
  cnt_t   cnt_q,   cnt_d;

  logic accept;
  logic hit;
  logic shift;

  assign accept = (state_q == RUN) && x_valid;
  assign hit    = accept && act_q[x];
  // COMMIT is the only state that refuses configuration bits.
  assign shift  = cfg_en && (state_q != COMMIT);

  // NOTE: every next-state signal gets a default at the top of the block, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    shd_d   = shd_q;
    bcnt_d  = bcnt_q;
    y_d     = y_q;
    yv_d    = accept;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    if (accept) begin
      y_d = act_q[x];
    end

    if (shift) begin
      shd_d  = {shd_q[DEPTH-2:0], cfg_bit};
      bcnt_d = bcnt_q + bcnt_t'(1);
    end

    case (state_q)
      RUN: begin
        if (cfg_en) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cfg_en && (bcnt_q == LAST_BIT)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        act_d   = shd_q;
        bcnt_d  = '0;
        done_d  = 1'b1;
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Clear takes priority over a coincident hit; the counter never wraps.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every register
  // samples the pre-edge values computed above regardless of statement order.
  // The tables are plain flops (not a RAM), so resetting them is legal and cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      act_q   <= RESET_TABLE;
      shd_q   <= '0;
      bcnt_q  <= '0;
      y_q     <= 1'b0;
      yv_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      bcnt_q  <= bcnt_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y        = y_q;
  assign y_valid  = yv_q;
  assign busy     = (state_q != RUN);
  assign cfg_done = done_q;
  assign hit_cnt  = cnt_q;

endmodule

// File: tb/tb_lut_prog.sv
// Randomised and directed bench for lut_prog against a queue-based reference model.
module tb_lut_prog;

  localparam int N       = 4;
  localparam int DEPTH   = 16;
  localparam int COUNT_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       x;
  logic               x_valid;
  logic               cfg_en;
  logic               cfg_bit;
  logic               cnt_clr;
  logic               y;
  logic               y_valid;
  logic               busy;
  logic               cfg_done;
  logic [COUNT_W-1:0] hit_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: the active table, the bits received so far, and a flag
  // saying a full table is waiting to be swapped in.
  logic [DEPTH-1:0] act_m;
  bit               shd_m[$];
  bit               commit_m;
  logic             y_m;
  logic             yv_m;
  logic             done_m;
  int               cnt_m;

  lut_prog #(.N(N), .RESET_TABLE(16'h0000), .COUNT_W(COUNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .x_valid  (x_valid),
    .cfg_en   (cfg_en),
    .cfg_bit  (cfg_bit),
    .cnt_clr  (cnt_clr),
    .y        (y),
    .y_valid  (y_valid),
    .busy     (busy),
    .cfg_done (cfg_done),
    .hit_cnt  (hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    act_m = 16'h0000;
    shd_m.delete();
    commit_m = 1'b0;
    y_m      = 1'b0;
    yv_m     = 1'b0;
    done_m   = 1'b0;
    cnt_m    = 0;
  endtask

  task automatic model_cycle(input logic [N-1:0] xi, input bit xv, input bit ce,
                             input bit cb, input bit clr);
    bit running = !commit_m && (shd_m.size() == 0);
    bit acc     = running && xv;
    yv_m = acc;
    if (acc) y_m = act_m[xi];
    done_m = commit_m;
    if (clr) cnt_m = 0;
    else if (acc && act_m[xi] && cnt_m < 255) cnt_m++;
    if (commit_m) begin
      for (int i = 0; i < DEPTH; i++) act_m[DEPTH-1-i] = shd_m[i];
      shd_m.delete();
      commit_m = 1'b0;
    end else if (ce) begin
      shd_m.push_back(cb);
      if (shd_m.size() == DEPTH) commit_m = 1'b1;
    end
  endtask

  task automatic compare(input string ctx);
    check({ctx, ".y"},        32'(y),        32'(y_m));
    check({ctx, ".y_valid"},  32'(y_valid),  32'(yv_m));
    check({ctx, ".cfg_done"}, 32'(cfg_done), 32'(done_m));
    check({ctx, ".hit_cnt"},  32'(hit_cnt),  32'(cnt_m));
    check({ctx, ".busy"},     32'(busy),     32'(commit_m || shd_m.size() != 0));
  endtask

  task automatic step(input string ctx, input logic [N-1:0] xi, input bit xv,
                      input bit ce, input bit cb, input bit clr);
    x       = xi;
    x_valid = xv;
    cfg_en  = ce;
    cfg_bit = cb;
    cnt_clr = clr;
    model_cycle(xi, xv, ce, cb, clr);
    @(posedge clk);
    #1;
    compare(ctx);
  endtask

  task automatic do_reset(input string ctx);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare(ctx);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic sweep(input string ctx);
    for (int i = 0; i < DEPTH; i++) step(ctx, N'(i), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic shift_bits(input string ctx, input logic [DEPTH-1:0] t, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) step(ctx, N'($urandom), 1'b0, 1'b1, t[i], 1'b0);
  endtask

  task automatic load_table(input string ctx, input logic [DEPTH-1:0] t);
    shift_bits(ctx, t, DEPTH - 1, 0);
    step(ctx, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; x = '0; x_valid = 1'b0; cfg_en = 1'b0; cfg_bit = 1'b0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset table reads all zero.
    sweep("reset_sweep");
    check("reset_sweep.hit_cnt_zero", 32'(hit_cnt), 32'd0);

    // Load 16'h8421 MSB first; cfg_done lands on the 17th edge after the first bit.
    shift_bits("load8421", 16'h8421, 15, 0);
    check("load8421.busy_at_bit16", 32'(busy), 32'd1);
    check("load8421.no_done_yet", 32'(cfg_done), 32'd0);
    step("load8421.commit", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("load8421.done_at_17", 32'(cfg_done), 32'd1);
    check("load8421.busy_low", 32'(busy), 32'd0);
    sweep("sweep8421");
    check("sweep8421.hit_cnt_4", 32'(hit_cnt), 32'd4);

    // Pause mid-load with lookups requested: nothing is served.
    shift_bits("pause.first", 16'h3C5A, 15, 8);
    for (int i = 0; i < 5; i++) begin
      step("pause.hold", N'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
      check("pause.no_valid", 32'(y_valid), 32'd0);
    end
    shift_bits("pause.second", 16'h3C5A, 7, 0);
    step("pause.commit", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    sweep("sweep3C5A");

    // Reset after 10 bits discards the partial table.
    shift_bits("midload", 16'hFFFF, 15, 6);
    do_reset("midload.reset");
    check("midload.busy_low", 32'(busy), 32'd0);
    sweep("midload.sweep");

    // Saturation, then clear beating a coincident hit.
    load_table("ones", 16'hFFFF);
    for (int i = 0; i < 300; i++) step("sat", N'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    check("sat.hit_cnt_255", 32'(hit_cnt), 32'd255);
    step("clr_vs_hit", 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    check("clr_vs_hit.zero", 32'(hit_cnt), 32'd0);
    check("clr_vs_hit.y", 32'(y), 32'd1);

    // Lookup and first config bit in the same RUN cycle.
    load_table("reload8421", 16'h8421);
    step("simul", 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    check("simul.y", 32'(y), 32'd1);
    check("simul.y_valid", 32'(y_valid), 32'd1);
    check("simul.in_load", 32'(busy), 32'd1);
    shift_bits("simul.rest", 16'hA5C3, 14, 0);
    step("simul.commit", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    sweep("sweepA5C3");

    // Random traffic: loads, pauses, lookups, clears and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      bit ce = (shd_m.size() != 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) do_reset("rand.reset");
      step("rand", N'($urandom), bit'($urandom_range(0, 1)), ce, bit'($urandom_range(0, 1)),
           $urandom_range(0, 39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
